// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if: requester-side and adapter-side signals of sdram_arbiter.
// slave modport is the arbiter's view; master modport is the surrounding
// requesters plus SDRAM adapter.
interface sdram_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 25,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  i_req0;
  logic                  i_req1;
  logic                  i_we0;
  logic                  i_we1;
  logic [ADDR_WIDTH-1:0] i_addr0;
  logic [ADDR_WIDTH-1:0] i_addr1;
  logic [DATA_WIDTH-1:0] i_wdata0;
  logic [DATA_WIDTH-1:0] i_wdata1;
  logic                  o_ack0;
  logic                  o_ack1;
  logic [DATA_WIDTH-1:0] o_rdata;
  logic                  o_mem_req;
  logic                  o_mem_we;
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic [DATA_WIDTH-1:0] o_mem_wdata;
  logic                  i_mem_ack;
  logic [DATA_WIDTH-1:0] i_mem_rdata;
  logic                  o_grant;

  modport slave (
    input  i_req0, i_req1, i_we0, i_we1, i_addr0, i_addr1, i_wdata0, i_wdata1,
    input  i_mem_ack, i_mem_rdata,
    output o_ack0, o_ack1, o_rdata, o_mem_req, o_mem_we, o_mem_addr,
    output o_mem_wdata, o_grant
  );

  modport master (
    output i_req0, i_req1, i_we0, i_we1, i_addr0, i_addr1, i_wdata0, i_wdata1,
    output i_mem_ack, i_mem_rdata,
    input  o_ack0, o_ack1, o_rdata, o_mem_req, o_mem_we, o_mem_addr,
    input  o_mem_wdata, o_grant
  );
endinterface

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: two-port, one-transaction-at-a-time arbiter in front of the
// SDRAM adapter. Port 0 (65C02 path) has fixed priority over port 1.
// Optional starvation guard for port 1: define SDRAM_ARB_STARVE_EN.
module sdram_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 25,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic            clk,
  input logic            reset,
  sdram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  grant_q, grant_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  any_req;
  logic                  win1;

`ifdef SDRAM_ARB_STARVE_EN
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt_q, starve_cnt_d;
`else
  localparam int unsigned starve_limit_unused = STARVE_LIMIT;
`endif

  assign any_req = bus.i_req0 | bus.i_req1;

  // Arbitration: port 0 wins unless idle, or the starvation guard fires.
  always_comb begin
    win1 = bus.i_req1 & ~bus.i_req0;
`ifdef SDRAM_ARB_STARVE_EN
    if (bus.i_req0 && bus.i_req1 && (starve_cnt_q == STARVE_MAX)) begin
      win1 = 1'b1;
    end
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; DONE is an unconditional one-cycle gap so a request
  // still held during the ack cycle is never re-granted.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (any_req) state_d = ST_BUSY;
      ST_BUSY: if (bus.i_mem_ack) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: request while BUSY, ack to the owner during DONE.
  always_comb begin
    bus.o_mem_req = (state_q == ST_BUSY);
    bus.o_ack0    = (state_q == ST_DONE) && !grant_q;
    bus.o_ack1    = (state_q == ST_DONE) &&  grant_q;
  end

  // Datapath next values: capture winner on grant, read data on completion.
  always_comb begin
    grant_d     = grant_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    if ((state_q == ST_IDLE) && any_req) begin
      grant_d     = win1;
      mem_we_d    = win1 ? bus.i_we1    : bus.i_we0;
      mem_addr_d  = win1 ? bus.i_addr1  : bus.i_addr0;
      mem_wdata_d = win1 ? bus.i_wdata1 : bus.i_wdata0;
    end
    if ((state_q == ST_BUSY) && bus.i_mem_ack && !mem_we_q) begin
      rdata_d = bus.i_mem_rdata;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_q     <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      grant_q     <= grant_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

`ifdef SDRAM_ARB_STARVE_EN
  // Starvation counter: counts port-0 grants that bypassed a waiting port 1.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (state_q == ST_IDLE) begin
      if (!bus.i_req1 || win1) begin
        starve_cnt_d = '0;
      end else begin
        starve_cnt_d = starve_cnt_q + 4'd1;
      end
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`endif

  assign bus.o_grant     = grant_q;
  assign bus.o_mem_we    = mem_we_q;
  assign bus.o_mem_addr  = mem_addr_q;
  assign bus.o_mem_wdata = mem_wdata_q;
  assign bus.o_rdata     = rdata_q;

endmodule
